imem_boot_loader: RTL
=====================

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 Parameter IMEM_DEPTH, 256, instruction memory capacity in 32-bit words.
REQ-002 Parameter ADDR_W, 32, width of the instruction memory byte address.
REQ-003 Port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous and active-high.
REQ-005 Port start_i  input  1  one-cycle pulse that begins a load.
REQ-006 Port byte_i  input  8  boot stream byte.
REQ-007 Port byte_valid_i  input  1  byte_i valid.
REQ-008 Port byte_ready_o  output  1  loader accepts byte_i this cycle.
REQ-009 Port imem_we_o  output  1  instruction memory write strobe.
REQ-010 Port imem_addr_o  output  ADDR_W  byte address of the written word.
REQ-011 Port imem_data_o  output  32  word written.
REQ-012 Port cpu_nrst_o  output  1  drives the CPU's active-low nrst_i; CPU runs only when high.
REQ-013 Port busy_o / done_o / err_o  output  1 each  load in progress / load complete / load failed.

Function
REQ-014 States SHALL be IDLE, HDR, LOAD, CHK (only with macro), DONE, ERR.
REQ-015 A byte SHALL transfer only when byte_valid_i && byte_ready_o are high on the same edge.
REQ-016 byte_ready_o SHALL be high in HDR, LOAD and CHK, except low in any cycle where imem_we_o is high.
REQ-017 Bytes SHALL pack little-endian: first byte of each group -> bits [7:0], fourth -> bits [31:24].
REQ-018 IDLE/DONE/ERR + start_i SHALL go to HDR next cycle, clear byte/word counters; start_i SHALL be ignored in HDR, LOAD, CHK.
REQ-019 HDR SHALL take 4 bytes as word count N; N==0 -> DONE (CHK with macro); N>IMEM_DEPTH -> ERR; else -> LOAD.
REQ-020 LOAD: the cycle after the 4th byte of word k, imem_we_o SHALL be high for exactly one cycle with imem_addr_o=4*k, imem_data_o=packed word, k counting 0..N-1.
REQ-021 After word N-1's write cycle, state SHALL go to DONE (CHK with macro) next cycle.
REQ-022 cpu_nrst_o SHALL be low in every state except DONE; high from the first cycle in DONE.
REQ-023 busy_o SHALL be high in HDR/LOAD/CHK; done_o high only in DONE; err_o high only in ERR.
REQ-024 imem_addr_o/imem_data_o SHALL be 0 whenever imem_we_o is low.
REQ-025 Byte counter SHALL wrap 3->0 per word; word counter SHALL never exceed N; no write SHALL occur at address >= 4*IMEM_DEPTH.

Reset
REQ-026 rst_i high SHALL force IDLE, all outputs 0 (cpu_nrst_o=0), counters and checksum 0 on the next edge.
REQ-027 rst_i mid-load SHALL abort with no further imem_we_o pulse; rst_i wins over start_i in the same cycle.

Configuration
REQ-028 Macro BOOT_CHECKSUM_EN defined: running XOR of all payload bytes (header excluded); CHK accepts one byte; match -> DONE, mismatch -> ERR.
REQ-029 Macro BOOT_CHECKSUM_EN undefined: no CHK state, no checksum logic; LOAD/HDR go directly to DONE.

Structure
REQ-030 Package boot_pkg SHALL hold the state enum, BOOT_HDR_BYTES=4 and BOOT_WORD_BYTES=4.
REQ-031 Sub-module boot_word_packer SHALL hold byte counter and little-endian assembly, emitting word + word_valid pulse; FSM in imem_boot_loader.

Verification
REQ-032 Reset, start_i, header 02 00 00 00, payload 13 00 00 00 93 00 10 00 -> writes (0x0, 0x00000013), (0x4, 0x00100093); cpu_nrst_o=1 one cycle after 2nd write.
REQ-033 Header 00 00 00 00 -> DONE, zero writes, done_o=1 (macro off).
REQ-034 Header 01 01 00 00 (N=257) with IMEM_DEPTH=256 -> err_o=1, zero writes, cpu_nrst_o stays 0.
REQ-035 byte_valid_i high every other cycle, byte held through write cycles -> identical writes, no byte lost or duplicated.
REQ-036 rst_i after 5 payload bytes -> no write, all outputs 0; new start_i then full load succeeds.
REQ-037 Macro on, N=1, payload 13 00 00 00: checksum 0x13 -> DONE; checksum 0x12 -> ERR, cpu_nrst_o=0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// BOOT_CHECKSUM_EN adds the CHK state for a trailing XOR checksum byte.
package boot_pkg;

    localparam int BOOT_HDR_BYTES  = 4;
    localparam int BOOT_WORD_BYTES = 4;

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } boot_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_DONE,
        ST_ERR
    } boot_state_e;
`endif

endpackage

// File: rtl/boot_word_packer.sv
// Little-endian byte-to-word assembler with a one-cycle word_valid pulse.
// Shows the would-be word combinationally so the header can be decoded early.
module boot_word_packer
    import boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        xfer_i,
    input  logic        emit_i,
    input  logic [7:0]  byte_i,
    output logic        last_o,
    output logic [31:0] next_word_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  r_cnt;
    logic [23:0] r_buf;
    logic [31:0] r_word;
    logic        r_valid;

    assign last_o       = (r_cnt == 2'(BOOT_WORD_BYTES - 1));
    assign next_word_o  = {byte_i, r_buf};
    assign word_o       = r_word;
    assign word_valid_o = r_valid;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_cnt   <= '0;
            r_buf   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (xfer_i) begin
                r_cnt <= r_cnt + 2'd1;
                unique case (r_cnt)
                    2'd0:    r_buf[7:0]   <= byte_i;
                    2'd1:    r_buf[15:8]  <= byte_i;
                    2'd2:    r_buf[23:16] <= byte_i;
                    default: begin
                        // Header words are decoded elsewhere and never emitted
                        if (emit_i) begin
                            r_word  <= next_word_o;
                            r_valid <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader FSM: header word count, payload words into IMEM, CPU release.
// BOOT_CHECKSUM_EN enables the trailing XOR checksum check (CHK state).
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_nrst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(IMEM_DEPTH + 1);

    boot_state_e r_state;
    boot_state_e w_next;

    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_wcnt;

    logic        w_busy;
    logic        w_we;
    logic        w_xfer;
    logic        w_start;
    logic        w_hdr_done;
    logic        w_last_word;
    logic        w_last;
    logic [31:0] w_hdr;
    logic [31:0] w_word;
    logic        w_word_valid;
    boot_state_e w_fin;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_csum;

    assign w_fin  = ST_CHK;
    assign w_busy = (r_state == ST_HDR) || (r_state == ST_LOAD) ||
                    (r_state == ST_CHK);
`else
    assign w_fin  = ST_DONE;
    assign w_busy = (r_state == ST_HDR) || (r_state == ST_LOAD);
`endif

    assign w_we = (r_state == ST_LOAD) && w_word_valid &&
                  (r_wcnt < CNT_W'(IMEM_DEPTH));
    assign byte_ready_o = w_busy && !w_we;
    assign w_xfer       = byte_valid_i && byte_ready_o;
    assign w_start      = start_i && ((r_state == ST_IDLE) ||
                          (r_state == ST_DONE) || (r_state == ST_ERR));
    assign w_hdr_done   = (r_state == ST_HDR) && w_xfer && w_last;
    assign w_last_word  = (r_wcnt == (r_n - CNT_W'(1)));

    assign imem_we_o   = w_we;
    assign imem_addr_o = w_we ? ADDR_W'({r_wcnt, 2'b00}) : '0;
    assign imem_data_o = w_we ? w_word : '0;
    assign cpu_nrst_o  = (r_state == ST_DONE);
    assign busy_o      = w_busy;
    assign done_o      = (r_state == ST_DONE);
    assign err_o       = (r_state == ST_ERR);

    boot_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (w_start),
        .xfer_i       (w_xfer),
        .emit_i       (r_state == ST_LOAD),
        .byte_i       (byte_i),
        .last_o       (w_last),
        .next_word_o  (w_hdr),
        .word_o       (w_word),
        .word_valid_o (w_word_valid)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    w_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_hdr_done) begin
                    if (w_hdr == 32'd0) begin
                        w_next = w_fin;
                    end else if (w_hdr > 32'(IMEM_DEPTH)) begin
                        w_next = ST_ERR;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (w_we && w_last_word) begin
                    w_next = w_fin;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CHK: begin
                if (w_xfer) begin
                    w_next = (byte_i == r_csum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_n    <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_hdr_done) begin
                r_n <= w_hdr[CNT_W-1:0];
            end
            if (w_we) begin
                r_wcnt <= r_wcnt + CNT_W'(1);
            end
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Only payload bytes feed the checksum; header and the check byte do not
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_csum <= '0;
        end else if (w_xfer && (r_state == ST_LOAD)) begin
            r_csum <= r_csum ^ byte_i;
        end
    end
`endif

endmodule
